// File: rtl/forward_hazard_unit.sv
// EX-operand forwarding selects and load-use / memory-wait stall control for a 5-stage MIPS pipeline.
// Optional stall performance counter enabled by defining HAZ_PERF_CNT_EN.
module forward_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wr_reg,
  input  logic                  id_is_load,
  input  logic                  mem_ready,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  bubble,
  output logic [CNT_W-1:0]      perf_stall_cnt
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_e;

  state_e                  state_q, state_d;
  logic                    ex_v_q, ex_we_q, ex_ld_q, ex_v_d, ex_we_d, ex_ld_d;
  logic                    mem_v_q, mem_we_q, mem_ld_q, mem_v_d, mem_we_d, mem_ld_d;
  logic                    wb_v_q, wb_we_q, wb_ld_q, wb_v_d, wb_we_d, wb_ld_d;
  logic [REG_ADDR_W-1:0]   ex_reg_q, mem_reg_q, wb_reg_q, ex_reg_d, mem_reg_d, wb_reg_d;
  logic [1:0]              fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic                    mem_wait, load_use;

  function automatic logic slot_hit(input logic v, input logic we,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] src);
    return v && we && (rd != '0) && (rd == src);
  endfunction

  // Newest producer wins: the one in EX now will be in MEM when the consumer reaches EX.
  function automatic logic [1:0] sel_for(input logic vld, input logic use_src,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input logic ex_hit, input logic mem_hit);
    if (!vld || !use_src) return 2'b00;
    if (ex_hit)           return 2'b01;
    if (mem_hit)          return 2'b10;
    return 2'b00;
  endfunction

  assign mem_wait = mem_v_q && mem_ld_q && !mem_ready;
  assign load_use = ex_v_q && ex_ld_q &&
                    ((id_uses_rs && slot_hit(1'b1, ex_we_q, ex_reg_q, id_rs)) ||
                     (id_uses_rt && slot_hit(1'b1, ex_we_q, ex_reg_q, id_rt)));

  assign stall  = mem_wait || load_use;
  assign bubble = !mem_wait && load_use;

  always_comb begin
    state_d   = state_q;
    ex_v_d    = ex_v_q;    ex_we_d  = ex_we_q;  ex_ld_d  = ex_ld_q;  ex_reg_d  = ex_reg_q;
    mem_v_d   = mem_v_q;   mem_we_d = mem_we_q; mem_ld_d = mem_ld_q; mem_reg_d = mem_reg_q;
    wb_v_d    = wb_v_q;    wb_we_d  = wb_we_q;  wb_ld_d  = wb_ld_q;  wb_reg_d  = wb_reg_q;
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    if (mem_wait) begin
      state_d = MEM_WAIT;
    end else begin
      wb_v_d  = mem_v_q;  wb_we_d  = mem_we_q; wb_ld_d  = mem_ld_q; wb_reg_d  = mem_reg_q;
      mem_v_d = ex_v_q;   mem_we_d = ex_we_q;  mem_ld_d = ex_ld_q;  mem_reg_d = ex_reg_q;
      if (load_use) begin
        state_d = LOAD_STALL;
        ex_v_d  = 1'b0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
      end else begin
        state_d  = RUN;
        ex_v_d   = id_valid;
        ex_we_d  = id_wr_en;
        ex_ld_d  = id_is_load;
        ex_reg_d = id_wr_reg;
        fwd_a_d  = sel_for(id_valid, id_uses_rs, id_rs,
                           slot_hit(ex_v_q, ex_we_q, ex_reg_q, id_rs),
                           slot_hit(mem_v_q, mem_we_q, mem_reg_q, id_rs));
        fwd_b_d  = sel_for(id_valid, id_uses_rt, id_rt,
                           slot_hit(ex_v_q, ex_we_q, ex_reg_q, id_rt),
                           slot_hit(mem_v_q, mem_we_q, mem_reg_q, id_rt));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ex_v_q  <= 1'b0;
      mem_v_q <= 1'b0;
      wb_v_q  <= 1'b0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ex_v_q  <= ex_v_d;
      mem_v_q <= mem_v_d;
      wb_v_q  <= wb_v_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // Slot payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    ex_we_q  <= ex_we_d;  ex_ld_q  <= ex_ld_d;  ex_reg_q  <= ex_reg_d;
    mem_we_q <= mem_we_d; mem_ld_q <= mem_ld_d; mem_reg_q <= mem_reg_d;
    wb_we_q  <= wb_we_d;  wb_ld_q  <= wb_ld_d;  wb_reg_q  <= wb_reg_d;
  end

  // The WB slot is shadow state only; no select can point at it after the next edge.
  logic unused_wb;
  assign unused_wb = ^{wb_v_q, wb_we_q, wb_ld_q, wb_reg_q, state_q};

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                       cnt_q <= '0;
    else if (stall && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
  end
  assign perf_stall_cnt = cnt_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed pipeline scenarios plus randomized traffic
// against a newest-producer-search reference model.
module tb_forward_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, mem_ready;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, bubble;
  logic [15:0] perf_stall_cnt;

  int vectors = 0;
  int miscompares = 0;

`ifdef HAZ_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .mem_ready(mem_ready),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .bubble(bubble),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight producers listed oldest-last (0 = EX, 1 = MEM, 2 = WB).
  typedef struct {
    logic       v;
    logic       we;
    logic       ld;
    logic [4:0] r;
  } slot_t;

  slot_t      m_pipe [3];
  logic [1:0] m_sel_a, m_sel_b;
  int         m_cnt;

  function automatic logic m_writes(input int i, input logic [4:0] src);
    return m_pipe[i].v && m_pipe[i].we && m_pipe[i].r != 5'd0 && m_pipe[i].r == src;
  endfunction

  function automatic logic [1:0] m_sel(input logic use_src, input logic [4:0] src);
    if (!id_valid || !use_src) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (m_writes(i, src)) return (i == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_memwait();
    return m_pipe[1].v && m_pipe[1].ld && !mem_ready;
  endfunction

  function automatic logic m_loaduse();
    return m_pipe[0].ld && ((id_uses_rs && m_writes(0, id_rs)) || (id_uses_rt && m_writes(0, id_rt)));
  endfunction

  function automatic logic [15:0] m_cnt_exp();
    return CNT_EN ? 16'(m_cnt) : 16'd0;
  endfunction

  task automatic tick();
    slot_t      np [3];
    logic [1:0] na, nb;
    int         nc;
    np = m_pipe; na = m_sel_a; nb = m_sel_b; nc = m_cnt;
    if (m_memwait() || m_loaduse()) nc = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    if (rst) begin
      for (int i = 0; i < 3; i++) np[i] = '{1'b0, 1'b0, 1'b0, 5'd0};
      na = 2'b00; nb = 2'b00; nc = 0;
    end else if (!m_memwait()) begin
      np[2] = m_pipe[1];
      np[1] = m_pipe[0];
      if (m_loaduse()) begin
        np[0] = '{1'b0, 1'b0, 1'b0, 5'd0};
        na = 2'b00; nb = 2'b00;
      end else begin
        np[0] = '{id_valid, id_wr_en, id_is_load, id_wr_reg};
        na = m_sel(id_uses_rs, id_rs);
        nb = m_sel(id_uses_rt, id_rt);
      end
    end
    @(posedge clk);
    m_pipe = np; m_sel_a = na; m_sel_b = nb; m_cnt = nc;
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic we,
                       input logic [4:0] wr, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_wr_en = we; id_wr_reg = wr; id_is_load = ld;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic flush();
    mem_ready = 1'b1;
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; nop();
    tick(); tick();
    rst = 1'b0; #1;
    vectors++;
    if (stall !== 1'b0 || bubble !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctl stall=%b bubble=%b expected 0/0", stall, bubble);
    end
    vectors++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      miscompares++; $display("FAIL reset_sel a=%b b=%b expected 00/00", fwd_a_sel, fwd_b_sel);
    end
    vectors++;
    if (perf_stall_cnt !== 16'd0) begin
      miscompares++; $display("FAIL reset_cnt got %0d expected 0", perf_stall_cnt);
    end
  endtask

  task automatic test_fwd_ex();
    flush();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("FAIL ex_fwd_stall got %b expected 0", stall);
    end
    tick(); nop();
    vectors++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
      miscompares++; $display("FAIL ex_fwd_sel a=%b b=%b expected 01/00", fwd_a_sel, fwd_b_sel);
    end
  endtask

  task automatic test_fwd_mem();
    flush();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0); tick();
    nop(); tick();
    drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0); tick();
    nop();
    vectors++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10) begin
      miscompares++; $display("FAIL mem_fwd_sel a=%b b=%b expected 00/10", fwd_a_sel, fwd_b_sel);
    end
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0); tick();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0); tick();
    nop();
    vectors++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
      miscompares++; $display("FAIL ex_priority_sel a=%b b=%b expected 01/01", fwd_a_sel, fwd_b_sel);
    end
  endtask

  task automatic test_load_use();
    flush();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1); tick();
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    vectors++;
    if (stall !== 1'b1 || bubble !== 1'b1) begin
      miscompares++; $display("FAIL load_use_ctl stall=%b bubble=%b expected 1/1", stall, bubble);
    end
    tick(); #1;
    vectors++;
    if (stall !== 1'b0 || bubble !== 1'b0) begin
      miscompares++; $display("FAIL load_stall_len stall=%b bubble=%b expected 0/0", stall, bubble);
    end
    tick(); nop();
    vectors++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin
      miscompares++; $display("FAIL load_use_sel a=%b b=%b expected 10/10", fwd_a_sel, fwd_b_sel);
    end
  endtask

  task automatic test_mem_wait();
    flush();
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0); tick();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1); tick();
    drive(1'b1, 5'd9, 5'd4, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0); tick();
    nop(); mem_ready = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (stall !== 1'b1 || bubble !== 1'b0 || fwd_a_sel !== 2'b10) begin
        miscompares++;
        $display("FAIL mem_wait_%0d stall=%b bubble=%b a=%b expected 1/0/10", k, stall, bubble, fwd_a_sel);
      end
      tick();
    end
    mem_ready = 1'b1; #1;
    vectors++;
    if (stall !== 1'b0 || fwd_a_sel !== 2'b10) begin
      miscompares++; $display("FAIL mem_wait_release stall=%b a=%b expected 0/10", stall, fwd_a_sel);
    end
    tick();
    vectors++;
    if (perf_stall_cnt !== (CNT_EN ? 16'd3 : 16'd0)) begin
      miscompares++; $display("FAIL mem_wait_cnt got %0d expected %0d", perf_stall_cnt, CNT_EN ? 3 : 0);
    end
  endtask

  task automatic test_r0_and_invalid();
    flush();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); tick();
    nop();
    vectors++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      miscompares++; $display("FAIL r0_sel a=%b b=%b expected 00/00", fwd_a_sel, fwd_b_sel);
    end
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0); tick();
    drive(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    nop();
    vectors++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      miscompares++; $display("FAIL invalid_id_sel a=%b b=%b expected 00/00", fwd_a_sel, fwd_b_sel);
    end
  endtask

  task automatic test_rst_mid_stall();
    flush();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1); tick();
    nop(); tick();
    mem_ready = 1'b0; #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL rst_pre_stall got %b expected 1", stall);
    end
    tick();
    rst = 1'b1; tick(); rst = 1'b0; #1;
    vectors++;
    if (stall !== 1'b0 || bubble !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid_stall stall=%b bubble=%b a=%b b=%b expected 0/0/00/00", stall, bubble, fwd_a_sel, fwd_b_sel);
    end
    vectors++;
    if (perf_stall_cnt !== 16'd0) begin
      miscompares++; $display("FAIL rst_mid_cnt got %0d expected 0", perf_stall_cnt);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0));
      vectors++;
      if (stall !== (m_memwait() || m_loaduse()) || bubble !== (!m_memwait() && m_loaduse())) begin
        miscompares++;
        $display("FAIL rand_ctl[%0d] stall=%b bubble=%b expected %b/%b", n, stall, bubble,
                 m_memwait() || m_loaduse(), !m_memwait() && m_loaduse());
      end
      vectors++;
      if (fwd_a_sel !== m_sel_a || fwd_b_sel !== m_sel_b) begin
        miscompares++;
        $display("FAIL rand_sel[%0d] a=%b b=%b expected %b/%b", n, fwd_a_sel, fwd_b_sel, m_sel_a, m_sel_b);
      end
      vectors++;
      if (perf_stall_cnt !== m_cnt_exp()) begin
        miscompares++; $display("FAIL rand_cnt[%0d] got %0d expected %0d", n, perf_stall_cnt, m_cnt_exp());
      end
      tick();
    end
    rst = 1'b0; mem_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m_pipe[i] = '{1'b0, 1'b0, 1'b0, 5'd0};
    m_sel_a = 2'b00; m_sel_b = 2'b00; m_cnt = 0;
    rst = 1'b1; mem_ready = 1'b1;
    nop();
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_mem_wait();
    test_r0_and_invalid();
    test_rst_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
